// File: rtl/uart_con_pkg.sv
// Shared definitions for the UART TX memory-mapped controller: descriptor
// field positions, controller FSM encoding and the default control address.
package uart_con_pkg;

  localparam int GO_BIT   = 31;
  localparam int BUSY_BIT = 30;
  localparam int DONE_BIT = 29;
  localparam int ADDR_MSB = 25;
  localparam int ADDR_LSB = 16;
  localparam int CNT_MSB  = 11;
  localparam int CNT_LSB  = 0;

  localparam logic [9:0] CTRL_ADDR_DEFAULT = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    POLL_WAIT,
    ACK,
    FETCH,
    FETCH_WAIT,
    SEND,
    STATUS
  } state_t;

  // Builds a descriptor/status word; every bit outside the named fields is 0.
  function automatic logic [31:0] pack_ctrl(input logic go, input logic bsy,
                                            input logic done, input logic [9:0] addr,
                                            input logic [11:0] cnt);
    logic [31:0] w;
    w                   = '0;
    w[GO_BIT]           = go;
    w[BUSY_BIT]         = bsy;
    w[DONE_BIT]         = done;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[CNT_MSB:CNT_LSB]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter. Accepts a byte on valid&&ready; ready also reasserts
// on the final stop-bit cycle so consecutive frames abut with no idle gap.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [BW-1:0] baud_cnt;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          accept;

  assign bit_end = (baud_cnt == BAUD_LAST);
  assign ready   = !active || ((bit_idx == 4'd9) && bit_end);
  assign accept  = valid && ready;

  // Line level is derived from the frame position; idle (and reset) is high.
  always_comb begin
    tx = 1'b1;
    if (active) begin
      if (bit_idx == 4'd0)      tx = 1'b0;
      else if (bit_idx <= 4'd8) tx = shreg[0];
    end
  end

  // Frame position and baud counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      active   <= 1'b0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (accept) begin
      active   <= 1'b1;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) active  <= 1'b0;
        else                 bit_idx <= bit_idx + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

  // Data shift register: LSB goes out first, shifted at the end of each data bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= data;
    end else if (active && bit_end && (bit_idx >= 4'd1) && (bit_idx <= 4'd8)) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: rtl/uart_tx_con.sv
// UART TX controller on the data-memory controller port. Polls a descriptor
// word, acknowledges it, streams the referenced bytes out of the serialiser
// and writes a DONE status word back to the same location.
import uart_con_pkg::*;

module uart_tx_con #(
  parameter int         CLKS_PER_BIT  = 868,
  parameter logic [9:0] CTRL_ADDR     = CTRL_ADDR_DEFAULT,
  parameter int         POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        nrst,
  output logic [3:0]  con_write,
  output logic [9:0]  con_addr,
  output logic [31:0] con_in,
  input  logic [31:0] con_out,
  output logic        tx,
  output logic        busy
);

  localparam int            PW        = $clog2(POLL_INTERVAL + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL);

  state_t        state, next_state;
  logic [PW-1:0] poll_cnt;
  logic [9:0]    orig_addr;
  logic [11:0]   orig_cnt;
  logic [9:0]    word_addr;
  logic [11:0]   remaining;
  logic [1:0]    byte_idx;
  logic [31:0]   wbuf;
  logic          ser_valid;
  logic          ser_ready;

  assign busy = (state != IDLE) && (state != POLL_WAIT);

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and memory-port / serialiser handshake outputs.
  always_comb begin
    next_state = state;
    con_write  = 4'b0000;
    con_addr   = '0;
    con_in     = '0;
    ser_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (poll_cnt == POLL_LAST) begin
          con_addr   = CTRL_ADDR;
          next_state = POLL_WAIT;
        end
      end
      POLL_WAIT: next_state = con_out[GO_BIT] ? ACK : IDLE;
      ACK: begin
        con_write  = 4'b1111;
        con_addr   = CTRL_ADDR;
        con_in     = pack_ctrl(1'b0, 1'b1, 1'b0, orig_addr, orig_cnt);
        next_state = (orig_cnt == '0) ? STATUS : FETCH;
      end
      FETCH: begin
        con_addr   = word_addr;
        next_state = FETCH_WAIT;
      end
      FETCH_WAIT: next_state = SEND;
      SEND: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          if (remaining == 12'd1)   next_state = STATUS;
          else if (byte_idx == 2'd3) next_state = FETCH;
        end
      end
      STATUS: begin
        con_write  = 4'b1111;
        con_addr   = CTRL_ADDR;
        con_in     = pack_ctrl(1'b0, 1'b0, 1'b1, orig_addr, orig_cnt);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Poll timer, descriptor latch and transfer bookkeeping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      poll_cnt  <= '0;
      orig_addr <= '0;
      orig_cnt  <= '0;
      word_addr <= '0;
      remaining <= '0;
      byte_idx  <= '0;
    end else begin
      case (state)
        IDLE: poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + PW'(1);
        POLL_WAIT: begin
          if (con_out[GO_BIT]) begin
            orig_addr <= con_out[ADDR_MSB:ADDR_LSB];
            orig_cnt  <= con_out[CNT_MSB:CNT_LSB];
            word_addr <= con_out[ADDR_MSB:ADDR_LSB];
            remaining <= con_out[CNT_MSB:CNT_LSB];
          end
        end
        FETCH_WAIT: byte_idx <= '0;
        SEND: begin
          if (ser_ready) begin
            remaining <= remaining - 12'd1;
            byte_idx  <= byte_idx + 2'd1;
            // 10-bit address wraps 3FF -> 000 naturally.
            if (byte_idx == 2'd3) word_addr <= word_addr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Word buffer: loaded on fetch, shifted so the next byte is always in [7:0].
  always_ff @(posedge clk) begin
    if (state == FETCH_WAIT)            wbuf <= con_out;
    else if (ser_valid && ser_ready)    wbuf <= {8'h00, wbuf[31:8]};
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk  (clk),
    .nrst (nrst),
    .data (wbuf[7:0]),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule

// File: doc/uart_tx_con.md
Name: uart_tx_con

Overview:
- Protocol controller on the data memory's controller-side port (con_write/con_addr/con_in/con_out).
- The core places a byte buffer and a descriptor word in data memory. This block fetches the buffer words and serialises the bytes out of a UART TX pin (8N1).
- On completion it writes a status word back, so firmware can poll it with an ordinary load.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- CTRL_ADDR, 10'h3FF, word address of the descriptor/status word.
- POLL_INTERVAL, 16, idle cycles between descriptor reads.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- con_write  output  4  byte write enables to data memory controller port.
- con_addr  output  10  word address to data memory controller port.
- con_in  output  32  write data to data memory.
- con_out  input  32  read data from data memory; valid on the rising edge one cycle after con_addr is driven.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from descriptor acceptance until the status write completes.

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous, active-low.
- Reset values: tx=1, busy=0, con_write=0, con_addr=0, con_in=0, state=IDLE, all counters 0. Reset mid-transfer aborts immediately: tx returns high and no status write is issued.
- Descriptor word format:
  - [31] GO
  - [30] BUSY
  - [29] DONE
  - [25:16] buffer word address
  - [11:0] byte count (0..4095)
  - all other bits written as 0
- IDLE: count POLL_INTERVAL cycles, then drive con_addr=CTRL_ADDR and go to POLL_WAIT.
- POLL_WAIT: sample con_out.
  - GO=0: back to IDLE.
  - GO=1: latch address and count, go to ACK.
- ACK: one cycle with con_write=4'b1111 and con_in = {0, BUSY=1, DONE=0, addr, count}. busy rises this cycle.
  - count=0: go straight to STATUS.
  - count>0: go to FETCH.
- FETCH: drive con_addr=current word address, go to FETCH_WAIT.
- FETCH_WAIT: latch con_out into a 32-bit shift buffer, set byte index to 0, go to SEND.
- SEND:
  - Hand the byte to the serialiser, little-endian: byte 0 = bits [7:0].
  - Wait for serialiser ready, then decrement remaining count.
  - remaining=0: go to STATUS.
  - byte index=3: increment word address and go to FETCH.
  - otherwise: next byte.
- Word address wraps 10'h3FF to 10'h000. No special handling, no error.
- STATUS: one cycle with con_write=4'b1111 and con_in = {GO=0, BUSY=0, DONE=1, original addr, original count}. Then busy=0 and return to IDLE.
- con_write is 0 in every state except ACK and STATUS. Only whole-word writes are issued.
- A descriptor rewritten by the core while busy is ignored; it is sampled again only at the next poll after STATUS.
- Serialiser timing:
  - Start bit (0), 8 data bits LSB first, stop bit (1), each exactly CLKS_PER_BIT cycles.
  - ready reasserts on the final stop-bit cycle.
  - Back-to-back bytes have no extra idle gap; the next start bit follows the stop bit directly.
  - Minimum inter-byte spacing is therefore 10*CLKS_PER_BIT cycles.
- Throughput: the word fetch (2 cycles) overlaps the last byte's stop bit. The serialiser accepts the next byte as soon as ready.

Decomposition:
- Shared package uart_con_pkg holds:
  - descriptor bit positions (GO_BIT=31, BUSY_BIT=30, DONE_BIT=29, ADDR_MSB/LSB=25/16, CNT_MSB/LSB=11/0)
  - FSM state encoding
  - the CTRL_ADDR default
- One sub-module, uart_tx_serializer.
  - Ports: clk, nrst, data[7:0], valid, ready, tx.
  - Parameter: CLKS_PER_BIT.
  - Holds the bit counter and baud counter.
- The top level holds the FSM, poll counter, address/count registers and the word buffer.

Test Plan:
- Reset/idle: nrst low then high, memory word 0x3FF=0 -> tx stays 1, busy 0, only reads of 0x3FF every POLL_INTERVAL+2 cycles, con_write never nonzero.
- Single word: CLKS_PER_BIT=4, mem[0x010]=32'h44434241, descriptor 32'h8010_0004 -> ACK writes 32'h4010_0004. tx emits 0x41,0x42,0x43,0x44 at 40-cycle spacing. STATUS writes 32'h2010_0004, busy falls.
- Partial word: count=6 starting at 0x020 -> exactly 6 bytes sent (word 0x020 bytes 0-3, word 0x021 bytes 0-1); exactly two fetches.
- Zero count: descriptor 32'h8030_0000 -> ACK then STATUS 32'h2030_0000 on consecutive cycles; tx never leaves 1.
- Wrap-around: address 0x3FE, count 12 -> fetches 0x3FE, 0x3FF, 0x000 in order; 12 bytes sent.
- Async reset mid-byte: assert nrst during bit 3 of the second byte -> tx=1 and busy=0 immediately (same cycle, no clock needed). No STATUS write; after release, resumes polling.
